// File: rtl/load_store_unit_pkg.sv
// -----------------------------------------------------------------------------
// load_store_unit_pkg
//   Shared definitions for the load/store unit:
//   - FSM state encoding (IDLE=0, READ=1, WRITE=2, RESP=3)
//   - access size codes (byte, halfword, word, illegal)
//   - captured request record
//   - request legality check (size, alignment, address range)
// -----------------------------------------------------------------------------
package load_store_unit_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   localparam logic [1:0] SZ_BYTE    = 2'b00;
   localparam logic [1:0] SZ_HALF    = 2'b01;
   localparam logic [1:0] SZ_WORD    = 2'b10;
   localparam logic [1:0] SZ_ILLEGAL = 2'b11;

   typedef struct packed {
      logic        write;
      logic [1:0]  size;
      logic        is_unsigned;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_t;

   // A request is rejected for an illegal size, a misaligned half/word,
   // or a word index beyond the end of the data memory.
   function automatic logic req_error(input logic [1:0]  size,
                                      input logic [31:0] addr,
                                      input int unsigned mem_words);
      logic [31:0] word_idx;
      word_idx = {2'b00, addr[31:2]};
      return (size == SZ_ILLEGAL)
          || ((size == SZ_HALF) && addr[0])
          || ((size == SZ_WORD) && (addr[1:0] != 2'b00))
          || (word_idx >= mem_words);
   endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// -----------------------------------------------------------------------------
// load_store_unit_if
//   Bundles the CPU request/response handshake and the word-wide data memory
//   port of the load/store unit.
//   Request : req_valid, req_ready, req_write, req_size, req_unsigned,
//             req_addr, req_wdata
//   Response: resp_valid, resp_rdata, resp_err
//   Memory  : mem_read, mem_write, mem_addr (word index), mem_wdata, mem_rdata
//   Modports: slave  - the load/store unit itself
//             master - the environment (CPU side and data memory)
// -----------------------------------------------------------------------------
interface load_store_unit_if;

   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;

   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;

   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   modport slave (
      input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
      output req_ready,
      output resp_valid, resp_rdata, resp_err,
      output mem_read, mem_write, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
      input  req_ready,
      input  resp_valid, resp_rdata, resp_err,
      input  mem_read, mem_write, mem_addr, mem_wdata,
      output mem_rdata
   );

endinterface

// File: rtl/load_store_unit_byte_lane.sv
// -----------------------------------------------------------------------------
// load_store_unit_byte_lane
//   Combinational little-endian lane logic.
//   i_word       : word read from memory (old word for stores, data for loads)
//   i_wdata      : right-aligned store data
//   i_size       : access size code
//   i_offset     : byte offset within the word (addr[1:0])
//   i_unsigned   : 1 = zero-extend loads, 0 = sign-extend
//   o_store_word : i_word with the target lane(s) replaced (whole i_wdata for words)
//   o_load_data  : selected lane, right-aligned and extended
// -----------------------------------------------------------------------------
module load_store_unit_byte_lane
   import load_store_unit_pkg::*;
(
   input  logic [31:0] i_word,
   input  logic [31:0] i_wdata,
   input  logic [1:0]  i_size,
   input  logic [1:0]  i_offset,
   input  logic        i_unsigned,
   output logic [31:0] o_store_word,
   output logic [31:0] o_load_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_byte = i_word[{i_offset, 3'b000} +: 8];
   assign w_half = i_word[{i_offset[1], 4'b0000} +: 16];

   always_comb begin
      // NOTE: outputs get a default before the case so no path leaves them
      // unassigned; otherwise synthesis infers a latch.
      o_store_word = i_word;
      case (i_size)
         SZ_BYTE: o_store_word[{i_offset, 3'b000} +: 8]     = i_wdata[7:0];
         SZ_HALF: o_store_word[{i_offset[1], 4'b0000} +: 16] = i_wdata[15:0];
         SZ_WORD: o_store_word = i_wdata;
         default: ;
      endcase
   end

   always_comb begin
      o_load_data = '0;
      case (i_size)
         SZ_BYTE: o_load_data = {{24{~i_unsigned & w_byte[7]}}, w_byte};
         SZ_HALF: o_load_data = {{16{~i_unsigned & w_half[15]}}, w_half};
         SZ_WORD: o_load_data = i_word;
         default: ;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//   Initiator-side access unit between the execute stage and a word-wide data
//   memory. One request at a time; sub-word stores are read-modify-write.
//   clk : clock, rising edge
//   rst : asynchronous active-low reset
//   bus : load_store_unit_if.slave (request, response and memory port)
//   Latency from acceptance to resp_valid: load 2, word store 2,
//   sub-word store 3, error 1.
// -----------------------------------------------------------------------------
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int unsigned MEM_WORDS = 256
) (
   input  logic              clk,
   input  logic              rst,
   load_store_unit_if.slave  bus
);

   state_t      r_state;
   req_t        r_req;
   logic [31:0] r_rdata;
   logic        r_req_ready;
   logic        r_mem_read;
   logic        r_mem_write;
   logic        r_resp_valid;
   logic        r_resp_err;

   logic        w_req_err;
   logic [31:0] w_store_word;
   logic [31:0] w_load_data;

   assign w_req_err = req_error(bus.req_size, bus.req_addr, MEM_WORDS);

   load_store_unit_byte_lane u_lane (
      .i_word       (r_rdata),
      .i_wdata      (r_req.wdata),
      .i_size       (r_req.size),
      .i_offset     (r_req.addr[1:0]),
      .i_unsigned   (r_req.is_unsigned),
      .o_store_word (w_store_word),
      .o_load_data  (w_load_data)
   );

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= ST_IDLE;
         r_req        <= '0;
         r_rdata      <= '0;
         r_req_ready  <= 1'b1;
         r_mem_read   <= 1'b0;
         r_mem_write  <= 1'b0;
         r_resp_valid <= 1'b0;
         r_resp_err   <= 1'b0;
      end else begin
         // Strobes are single-cycle; the state that needs one re-asserts it.
         r_mem_read   <= 1'b0;
         r_mem_write  <= 1'b0;
         r_resp_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (bus.req_valid) begin
                  r_req       <= '{write:       bus.req_write,
                                   size:        bus.req_size,
                                   is_unsigned: bus.req_unsigned,
                                   addr:        bus.req_addr,
                                   wdata:       bus.req_wdata};
                  r_req_ready <= 1'b0;
                  if (w_req_err) begin
                     r_state      <= ST_RESP;
                     r_resp_valid <= 1'b1;
                     r_resp_err   <= 1'b1;
                  end else if (bus.req_write && (bus.req_size == SZ_WORD)) begin
                     r_state     <= ST_WRITE;
                     r_mem_write <= 1'b1;
                  end else begin
                     r_state    <= ST_READ;
                     r_mem_read <= 1'b1;
                  end
               end
            end
            ST_READ: begin
               r_rdata <= bus.mem_rdata;
               if (r_req.write) begin
                  r_state     <= ST_WRITE;
                  r_mem_write <= 1'b1;
               end else begin
                  r_state      <= ST_RESP;
                  r_resp_valid <= 1'b1;
               end
            end
            ST_WRITE: begin
               r_state      <= ST_RESP;
               r_resp_valid <= 1'b1;
            end
            ST_RESP: begin
               r_state     <= ST_IDLE;
               r_req_ready <= 1'b1;
               r_resp_err  <= 1'b0;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.req_ready  = r_req_ready;
   assign bus.mem_read   = r_mem_read;
   assign bus.mem_write  = r_mem_write;
   assign bus.mem_addr   = (r_mem_read || r_mem_write) ? {2'b00, r_req.addr[31:2]} : '0;
   // Word stores pass i_wdata through the lane logic unchanged.
   assign bus.mem_wdata  = r_mem_write ? w_store_word : '0;
   assign bus.resp_valid = r_resp_valid;
   assign bus.resp_err   = r_resp_err;
   assign bus.resp_rdata = (r_resp_valid && !r_resp_err && !r_req.write) ? w_load_data : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//   Drives load_store_unit through directed scenarios and randomized traffic,
//   with a word-array data memory and a reference model of memory contents,
//   load extraction/extension, store merging, legality and latency.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

   localparam int unsigned MEM_WORDS = 256;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   load_store_unit_if bus ();

   load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   logic [31:0] env_mem [MEM_WORDS];
   logic [31:0] ref_mem [MEM_WORDS];
   int n_cmp = 0;
   int n_bad = 0;

   // Data memory: combinational read, whole-word write on the clock edge.
   assign bus.mem_rdata = bus.mem_read ? env_mem[bus.mem_addr[7:0]] : 32'h0;
   always @(posedge clk)
      if (bus.mem_write && (bus.mem_addr < MEM_WORDS))
         env_mem[bus.mem_addr[7:0]] <= bus.mem_wdata;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic bit ref_err(input logic [1:0] size, input logic [31:0] addr);
      return (size == 2'd3) || ((size == 2'd1) && (addr % 2 != 0))
          || ((size == 2'd2) && (addr % 4 != 0)) || ((addr / 4) >= MEM_WORDS);
   endfunction

   function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] size,
                                            input logic uns, input logic [31:0] addr);
      int unsigned sh;
      logic [31:0] v;
      case (size)
         2'd0: begin
            sh = 8 * (addr % 4);
            v  = (w >> sh) & 32'hFF;
            if (!uns && v >= 128) v = v | 32'hFFFF_FF00;
         end
         2'd1: begin
            sh = 16 * ((addr / 2) % 2);
            v  = (w >> sh) & 32'hFFFF;
            if (!uns && v >= 32768) v = v | 32'hFFFF_0000;
         end
         default: v = w;
      endcase
      return v;
   endfunction

   function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [31:0] wd,
                                             input logic [1:0] size, input logic [31:0] addr);
      int unsigned sh;
      logic [31:0] mask;
      case (size)
         2'd0: begin
            sh = 8 * (addr % 4);
            mask = 32'hFF << sh;
            return (w & ~mask) | ((wd & 32'hFF) << sh);
         end
         2'd1: begin
            sh = 16 * ((addr / 2) % 2);
            mask = 32'hFFFF << sh;
            return (w & ~mask) | ((wd & 32'hFFFF) << sh);
         end
         default: return wd;
      endcase
   endfunction

   // Issue one request starting at a negedge; returns at the negedge of the
   // response cycle. waits = negedges spent waiting for req_ready.
   task automatic do_req(input logic wr, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata, input bit hold,
                         output logic [31:0] rdata, output int waits);
      bit err, got;
      int exp_lat, exp_rd, exp_wr, cycles, nrd, nwr, ready_hi;
      logic [31:0] idx, exp_rdata, exp_wdata, wd_seen, ad_seen;
      err = ref_err(size, addr);
      idx = addr / 4;
      exp_rdata = 32'h0;
      exp_wdata = 32'h0;
      if (!err && !wr) exp_rdata = ref_load(ref_mem[idx[7:0]], size, uns, addr);
      if (!err && wr)  exp_wdata = ref_store(ref_mem[idx[7:0]], wdata, size, addr);
      exp_lat = err ? 1 : ((wr && size != 2'd2) ? 3 : 2);
      exp_rd  = (!err && !(wr && size == 2'd2)) ? 1 : 0;
      exp_wr  = (!err && wr) ? 1 : 0;

      bus.req_valid    = 1'b1;
      bus.req_write    = wr;
      bus.req_size     = size;
      bus.req_unsigned = uns;
      bus.req_addr     = addr;
      bus.req_wdata    = wdata;
      waits = 0;
      while (!bus.req_ready && waits < 20) begin
         @(negedge clk);
         waits++;
      end
      rdata = 32'h0;
      if (!bus.req_ready) begin
         check("accept_timeout", 32'(bus.req_ready), 32'd1);
         bus.req_valid = 1'b0;
         return;
      end
      @(negedge clk);
      if (!hold) bus.req_valid = 1'b0;
      cycles = 1; got = 0; nrd = 0; nwr = 0; ready_hi = 0;
      wd_seen = 32'h0; ad_seen = 32'h0;
      while (!got && cycles <= 6) begin
         if (bus.req_ready) ready_hi++;
         if (bus.mem_read) begin nrd++; ad_seen = bus.mem_addr; end
         if (bus.mem_write) begin nwr++; ad_seen = bus.mem_addr; wd_seen = bus.mem_wdata; end
         if (bus.resp_valid) got = 1;
         else begin
            @(negedge clk);
            cycles++;
         end
      end
      check("latency",    cycles, exp_lat);
      check("resp_valid", 32'(bus.resp_valid), 32'd1);
      check("resp_err",   32'(bus.resp_err), 32'(err));
      check("resp_rdata", bus.resp_rdata, exp_rdata);
      check("mem_reads",  nrd, exp_rd);
      check("mem_writes", nwr, exp_wr);
      check("ready_low",  ready_hi, 0);
      if (exp_rd + exp_wr > 0) check("mem_addr", ad_seen, idx);
      if (exp_wr != 0) check("mem_wdata", wd_seen, exp_wdata);
      if (!err && wr) ref_mem[idx[7:0]] = exp_wdata;
      rdata = bus.resp_rdata;
   endtask

   initial begin
      logic [31:0] rd, v, a;
      logic [1:0]  sz;
      int w, nw, r;

      for (int i = 0; i < int'(MEM_WORDS); i++) begin
         v = $urandom;
         env_mem[i] = v;
         ref_mem[i] = v;
      end
      bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'd0;
      bus.req_unsigned = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_req_ready",  32'(bus.req_ready), 32'd1);
      check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      check("rst_mem_read",   32'(bus.mem_read), 32'd0);
      check("rst_mem_write",  32'(bus.mem_write), 32'd0);
      check("rst_mem_addr",   bus.mem_addr, 32'h0);
      check("rst_resp_rdata", bus.resp_rdata, 32'h0);
      rst = 1'b1;
      @(negedge clk);

      // 1. word store / load
      do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0, rd, w);
      do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0, rd, w);
      check("t1_lw", rd, 32'hDEAD_BEEF);

      // 2. sub-word read-modify-write
      do_req(1'b1, 2'd2, 1'b0, 32'h20, 32'h1122_3344, 1'b0, rd, w);
      do_req(1'b1, 2'd0, 1'b0, 32'h21, 32'h0000_00AA, 1'b0, rd, w);
      do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b0, rd, w);
      check("t2_lw", rd, 32'h1122_AA44);

      // 3. extension
      do_req(1'b1, 2'd2, 1'b0, 32'h30, 32'h80FF_7F01, 1'b0, rd, w);
      do_req(1'b0, 2'd0, 1'b0, 32'h32, 32'h0, 1'b0, rd, w);
      check("t3_lb", rd, 32'hFFFF_FFFF);
      do_req(1'b0, 2'd0, 1'b1, 32'h32, 32'h0, 1'b0, rd, w);
      check("t3_lbu", rd, 32'h0000_00FF);
      do_req(1'b0, 2'd1, 1'b0, 32'h32, 32'h0, 1'b0, rd, w);
      check("t3_lh", rd, 32'hFFFF_80FF);
      do_req(1'b0, 2'd1, 1'b1, 32'h30, 32'h0, 1'b0, rd, w);
      check("t3_lhu", rd, 32'h0000_7F01);

      // 4. errors
      do_req(1'b0, 2'd2, 1'b0, 32'h02,  32'h0, 1'b0, rd, w);
      do_req(1'b0, 2'd1, 1'b0, 32'h03,  32'h0, 1'b0, rd, w);
      do_req(1'b0, 2'd3, 1'b0, 32'h40,  32'h0, 1'b0, rd, w);
      do_req(1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 1'b0, rd, w);
      do_req(1'b1, 2'd2, 1'b0, 32'h400, 32'h1234_5678, 1'b0, rd, w);

      // 5. reset in the READ cycle of a byte store
      bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'd0;
      bus.req_addr = 32'h20; bus.req_wdata = 32'h55;
      w = 0;
      while (!bus.req_ready && w < 20) begin @(negedge clk); w++; end
      @(negedge clk);
      bus.req_valid = 1'b0;
      check("t5_in_read", 32'(bus.mem_read), 32'd1);
      rst = 1'b0;
      #1;
      check("t5_ready",    32'(bus.req_ready), 32'd1);
      check("t5_read_off", 32'(bus.mem_read), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      nw = 0;
      for (int i = 0; i < 4; i++) begin
         if (bus.mem_write) nw++;
         @(negedge clk);
      end
      check("t5_no_write", nw, 0);
      do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b0, rd, w);
      check("t5_word_kept", rd, 32'h1122_AA44);

      // 6. back-to-back with req_valid held high
      v = $urandom;
      do_req(1'b1, 2'd2, 1'b0, 32'h44, v, 1'b1, rd, w);
      do_req(1'b0, 2'd2, 1'b0, 32'h44, 32'h0, 1'b1, rd, w);
      check("t6_lw_accept_wait", w, 1);
      check("t6_lw_data", rd, v);
      do_req(1'b1, 2'd0, 1'b0, 32'h45, 32'h0000_00C3, 1'b0, rd, w);
      check("t6_sb_accept_wait", w, 1);

      // Randomized traffic over a small window so words are revisited
      for (int n = 0; n < 300; n++) begin
         r = $urandom_range(0, 9);
         sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
         a = $urandom_range(0, 127);
         if ($urandom_range(0, 3) != 0) begin
            if (sz == 2'd1) a = a & 32'hFFFF_FFFE;
            if (sz == 2'd2) a = a & 32'hFFFF_FFFC;
         end
         if ($urandom_range(0, 15) == 0) a = a + 32'h400;
         do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
                (n != 299) && ($urandom_range(0, 1) == 1), rd, w);
      end
      bus.req_valid = 1'b0;
      repeat (3) @(negedge clk);

      for (int i = 0; i < int'(MEM_WORDS); i++)
         check($sformatf("mem[%0d]", i), env_mem[i], ref_mem[i]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
